// File: rtl/cons_inject_sched.sv
// Console input scheduler: merges live UART bytes and a scripted command FIFO
// into the console FIFO write port, with boot gating and inter-character pacing.
module cons_inject_sched #(
  parameter int         DEPTH    = 16,
  parameter int         AW       = 4,
  parameter int         CHAR_GAP = 50000,
  parameter logic [7:0] END_CHAR = 8'h23
) (
  input  logic          clk,
  input  logic          RST_X,
  input  logic [63:0]   w_mtime,
  input  logic [63:0]   min_time,
  input  logic          r_consf_en,
  input  logic          uart_rx_valid,
  input  logic [7:0]    uart_rx_data,
  output logic          uart_rx_ready,
  input  logic          cmd_wr_en,
  input  logic [7:0]    cmd_wr_data,
  output logic [AW:0]   cmd_count,
  output logic          cmd_full,
  output logic          cmd_overflow,
  output logic          cmd_done,
  output logic          we,
  output logic [7:0]    key,
  output logic          boot_done,
  output logic          busy
);

  // state | meaning
  // IDLE  | waiting for a live or scripted grant
  // ISSUE | we asserted for the granted byte
  // GAP   | inter-character pacing, no grants
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  localparam int GW = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [GW-1:0]   gap_cnt;
  logic            push, pop, live_go, cmd_empty;
  logic [7:0]      head;

  // Gated by reset so the live port never looks ready while held in reset.
  assign uart_rx_ready = RST_X & (state == IDLE) & ~r_consf_en;
  assign live_go       = uart_rx_valid & uart_rx_ready;
  assign cmd_full      = (cmd_count == (AW+1)'(DEPTH));
  assign cmd_empty     = (cmd_count == '0);
  assign push          = cmd_wr_en & ~cmd_full;
  assign pop           = ~live_go & boot_done & ~cmd_empty & ~r_consf_en & (state == IDLE);
  assign head          = mem[rd_ptr];
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_wr_data;
  end

  always_ff @(posedge clk or negedge RST_X) begin
    if (!RST_X) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cmd_count    <= '0;
      cmd_overflow <= 1'b0;
      boot_done    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cmd_count <= cmd_count + 1'b1;
      else if (!push && pop) cmd_count <= cmd_count - 1'b1;
      if (cmd_wr_en && cmd_full) cmd_overflow <= 1'b1;
      if (w_mtime >= min_time)   boot_done    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST_X) begin
    if (!RST_X) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      we       <= 1'b0;
      key      <= '0;
      cmd_done <= 1'b0;
    end else begin
      we       <= 1'b0;
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (live_go) begin
            key   <= uart_rx_data;
            we    <= 1'b1;
            state <= ISSUE;
          end else if (pop) begin
            // The terminator is swallowed here and never reaches the console.
            if (head != END_CHAR) begin
              key   <= head;
              we    <= 1'b1;
              state <= ISSUE;
            end else begin
              cmd_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (CHAR_GAP == 0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= GW'(CHAR_GAP - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state   <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cons_inject_sched.sv
// Directed bench for cons_inject_sched with a byte scoreboard on the console write port.
module tb_cons_inject_sched;

  localparam int GAPC = 4;

  logic        clk = 1'b0;
  logic        RST_X = 1'b0;
  logic [63:0] w_mtime = 64'd50;
  logic [63:0] min_time = 64'd100;
  logic        r_consf_en = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_rx_ready;
  logic        cmd_wr_en = 1'b0;
  logic [7:0]  cmd_wr_data = 8'h00;
  logic [4:0]  cmd_count;
  logic        cmd_full, cmd_overflow, cmd_done, we, boot_done, busy;
  logic [7:0]  key;

  cons_inject_sched #(.DEPTH(16), .AW(4), .CHAR_GAP(GAPC), .END_CHAR(8'h23)) dut (
    .clk(clk), .RST_X(RST_X), .w_mtime(w_mtime), .min_time(min_time),
    .r_consf_en(r_consf_en), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_ready(uart_rx_ready), .cmd_wr_en(cmd_wr_en), .cmd_wr_data(cmd_wr_data),
    .cmd_count(cmd_count), .cmd_full(cmd_full), .cmd_overflow(cmd_overflow),
    .cmd_done(cmd_done), .we(we), .key(key), .boot_done(boot_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         we_cyc[$];
  int         done_cnt = 0;
  int         done_we = 0;
  logic       prev_we = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (we) begin
      chk("we_single_cycle", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) chk("unexpected_we", 64'(key), 64'h1FF);
      else                   chk("key", 64'(key), 64'(exp_q.pop_front()));
      we_cyc.push_back(cyc);
    end
    if (cmd_done) begin
      done_cnt++;
      if (we) done_we++;
    end
    prev_we = we;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic [7:0] b, input bit sb);
    cmd_wr_en   = 1'b1;
    cmd_wr_data = b;
    if (sb) exp_q.push_back(b);
    tick(1);
    cmd_wr_en = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (exp_q.size() == 0 && !busy && cmd_count == 0) done = 1'b1;
      else tick(1);
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int b0, c0, d0;

    // reset
    tick(2);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_key", 64'(key), 64'd0);
    chk("rst_ready", 64'(uart_rx_ready), 64'd0);
    chk("rst_count", 64'(cmd_count), 64'd0);
    chk("rst_boot", 64'(boot_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    RST_X = 1'b1;
    tick(2);

    // 1: boot gating and pacing
    b0 = we_cyc.size();
    push_cmd(8'h6C, 1'b1);
    push_cmd(8'h73, 1'b1);
    push_cmd(8'h0A, 1'b1);
    tick(10);
    chk("t1_count3", 64'(cmd_count), 64'd3);
    chk("t1_no_boot", 64'(boot_done), 64'd0);
    chk("t1_no_we", 64'(we_cyc.size() - b0), 64'd0);
    w_mtime = 64'd100;
    c0 = cyc;
    drain("t1_drain", 100);
    chk("t1_boot", 64'(boot_done), 64'd1);
    chk("t1_count0", 64'(cmd_count), 64'd0);
    chk("t1_n", 64'(we_cyc.size() - b0), 64'd3);
    if (we_cyc.size() - b0 == 3) begin
      chk("t1_first_lat", 64'(we_cyc[b0] - c0), 64'd2);
      chk("t1_space01", 64'(we_cyc[b0+1] - we_cyc[b0]), 64'(GAPC + 2));
      chk("t1_space12", 64'(we_cyc[b0+2] - we_cyc[b0+1]), 64'(GAPC + 2));
    end

    // 2: backpressure
    r_consf_en = 1'b1;
    b0 = we_cyc.size();
    push_cmd(8'h31, 1'b1);
    push_cmd(8'h32, 1'b1);
    tick(20);
    chk("t2_no_we", 64'(we_cyc.size() - b0), 64'd0);
    chk("t2_no_pop", 64'(cmd_count), 64'd2);
    r_consf_en = 1'b0;
    c0 = cyc;
    drain("t2_drain", 100);
    chk("t2_n", 64'(we_cyc.size() - b0), 64'd2);
    if (we_cyc.size() - b0 == 2) chk("t2_lat", 64'(we_cyc[b0] - c0), 64'd1);

    // 3: live beats scripted
    r_consf_en = 1'b1;
    b0 = we_cyc.size();
    exp_q.push_back(8'h41);
    push_cmd(8'h62, 1'b1);
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h41;
    r_consf_en    = 1'b0;
    @(negedge clk);
    chk("t3_ready", 64'(uart_rx_ready), 64'd1);
    tick(1);
    uart_rx_valid = 1'b0;
    chk("t3_ready_issue", 64'(uart_rx_ready), 64'd0);
    drain("t3_drain", 100);
    chk("t3_n", 64'(we_cyc.size() - b0), 64'd2);
    if (we_cyc.size() - b0 == 2) chk("t3_space", 64'(we_cyc[b0+1] - we_cyc[b0]), 64'(GAPC + 2));

    // 4: overflow
    r_consf_en = 1'b1;
    for (int i = 0; i < 16; i++) push_cmd(8'(8'h80 + i), 1'b1);
    chk("t4_full16", 64'(cmd_full), 64'd1);
    chk("t4_no_ovf_yet", 64'(cmd_overflow), 64'd0);
    push_cmd(8'hEE, 1'b0);
    chk("t4_count", 64'(cmd_count), 64'd16);
    chk("t4_full", 64'(cmd_full), 64'd1);
    chk("t4_ovf", 64'(cmd_overflow), 64'd1);
    r_consf_en = 1'b0;
    drain("t4_drain", 300);
    chk("t4_ovf_sticky", 64'(cmd_overflow), 64'd1);

    // 5: terminator
    r_consf_en = 1'b1;
    b0 = we_cyc.size();
    d0 = done_cnt;
    push_cmd(8'h61, 1'b1);
    push_cmd(8'h23, 1'b0);
    push_cmd(8'h62, 1'b1);
    r_consf_en = 1'b0;
    drain("t5_drain", 100);
    chk("t5_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t5_done_no_we", 64'(done_we), 64'd0);
    chk("t5_n", 64'(we_cyc.size() - b0), 64'd2);
    if (we_cyc.size() - b0 == 2) chk("t5_space", 64'(we_cyc[b0+1] - we_cyc[b0]), 64'(GAPC + 3));

    // 6: reset mid-GAP
    r_consf_en = 1'b1;
    b0 = we_cyc.size();
    for (int i = 0; i < 4; i++) push_cmd(8'(8'h71 + i), 1'b1);
    r_consf_en = 1'b0;
    for (int i = 0; i < 20 && we_cyc.size() == b0; i++) tick(1);
    chk("t6_first", 64'(we_cyc.size() - b0), 64'd1);
    tick(2);
    chk("t6_in_gap", 64'(busy), 64'd1);
    RST_X = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_we", 64'(we), 64'd0);
    chk("t6_key", 64'(key), 64'd0);
    chk("t6_ready", 64'(uart_rx_ready), 64'd0);
    chk("t6_count", 64'(cmd_count), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_boot", 64'(boot_done), 64'd0);
    chk("t6_ovf", 64'(cmd_overflow), 64'd0);
    chk("t6_done", 64'(cmd_done), 64'd0);
    tick(3);
    RST_X = 1'b1;
    b0 = we_cyc.size();
    tick(20);
    chk("t6_quiet", 64'(we_cyc.size() - b0), 64'd0);
    chk("t6_count_after", 64'(cmd_count), 64'd0);
    chk("t6_reboot", 64'(boot_done), 64'd1);
    push_cmd(8'h55, 1'b1);
    drain("t6_drain", 50);
    chk("t6_n", 64'(we_cyc.size() - b0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
